fpu_sequencer: RTL and testbench
================================

FPU_SEQUENCER -- requirements
Module: fpu_sequencer

Interface
REQ-001 SHALL have parameter IMEM_AW, default 4, instruction-address width (16-entry program).
REQ-002 SHALL have parameter RET_W, default 8, retired-instruction counter width.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  pulse; begins execution at address 0 when in IDLE.
REQ-006 abort  input  1  level; forces return to IDLE.
REQ-007 imem_addr  output  IMEM_AW  instruction fetch address (= PC).
REQ-008 imem_data  input  12  instruction word, valid one cycle after imem_addr (synchronous ROM).
REQ-009 rf_raddr_a, rf_raddr_b  output  2 each  BF16 register-file read addresses (rs1, rs2).
REQ-010 rf_waddr  output  2; rf_we  output  1  register-file write address and strobe.
REQ-011 fpu_op  output  2; fpu_valid  output  1; fpu_ready  input  1  FPU issue handshake.
REQ-012 fpu_done  input  1  one-cycle pulse: FPU result available this cycle.
REQ-013 busy  output  1; halted  output  1; retired  output  RET_W  status.

Function
REQ-014 Instruction format SHALL be [11:10] opcode (00 ADD, 01 SUB, 10 MUL, 11 HALT), [9:8] rd, [7:6] rs1, [5:4] rs2, [3:0] ignored.
REQ-015 FSM SHALL have states IDLE, FETCH, DECODE, ISSUE, WAIT, WB, HALT.
REQ-016 IDLE -> FETCH on start, PC cleared to 0 in the same edge; start ignored in all other states.
REQ-017 FETCH -> DECODE unconditionally (ROM latency 1 cycle); imem_addr = PC throughout.
REQ-018 DECODE: latch instruction; opcode HALT -> HALT, else -> ISSUE.
REQ-019 ISSUE: fpu_valid = 1, fpu_op, rf_raddr_a/b held stable; -> WAIT on the cycle fpu_valid && fpu_ready.
REQ-020 WAIT: fpu_valid = 0; -> WB on fpu_done; fpu_done outside WAIT SHALL be ignored.
REQ-021 WB: rf_we = 1 for exactly one cycle with rf_waddr = rd; PC <= PC+1 (modulo 2^IMEM_AW, 15 wraps to 0); retired <= retired+1, saturating at all-ones; -> FETCH.
REQ-022 HALT: halted = 1, PC frozen; -> FETCH at PC 0 on start (restart), retired preserved.
REQ-023 busy = 1 in FETCH, DECODE, ISSUE, WAIT, WB; else 0.
REQ-024 abort SHALL take priority over every transition: next state IDLE, fpu_valid and rf_we deasserted on the following cycle, no WB of an in-flight op, PC and retired preserved.
REQ-025 start and abort in the same cycle: abort wins.
REQ-026 Minimum per-instruction latency (fpu_ready=1, fpu_done one cycle after acceptance) SHALL be 5 cycles FETCH-to-FETCH.
REQ-027 All outputs SHALL be registered or decoded solely from registered state (no combinational path from fpu_ready/fpu_done to outputs).

Reset
REQ-028 On reset: state IDLE, PC 0, retired 0, fpu_valid 0, rf_we 0, busy 0, halted 0, rf addresses 0, fpu_op 0.
REQ-029 Reset mid-operation SHALL discard the in-flight instruction without any rf_we pulse.

Structure
REQ-030 Shared package fpu_seq_pkg SHALL hold the state enum, opcode constants, instruction-field positions and default widths.
REQ-031 PC SHALL be a sub-module seq_pc (IMEM_AW bits; clear, increment inputs; synchronous active-high reset); the FSM stays in fpu_sequencer.

Verification
REQ-032 Program ADD r1,r2,r3; HALT; fpu_ready=1, fpu_done 1 cycle after accept -> one rf_we with rf_waddr=1, halted=1, retired=1, PC=1.
REQ-033 fpu_ready held low 4 cycles in ISSUE -> fpu_valid held 4 cycles, rf_raddr_a/b/fpu_op stable, single acceptance.
REQ-034 Spurious fpu_done pulse in ISSUE, then real pulse in WAIT -> exactly one WB.
REQ-035 16 non-HALT instructions, then address 0 again -> PC wraps 15->0, retired=16, no halt.
REQ-036 abort asserted in WAIT -> IDLE next cycle, no rf_we, PC unchanged; start with abort same cycle -> stays IDLE.
REQ-037 reset during ISSUE -> all outputs at reset values next cycle; retired saturates at 255 after 256 retirements (long run).

Source files
------------

// File: rtl/fpu_seq_pkg.sv
// -----------------------------------------------------------------------------
// fpu_seq_pkg
// Shared definitions for the BF16 FPU instruction sequencer: FSM state
// encoding, opcode values, instruction-word field positions and default
// widths. Imported by fpu_sequencer and seq_pc.
// -----------------------------------------------------------------------------
package fpu_seq_pkg;

   // Default widths
   localparam int DEF_IMEM_AW = 4;   // 16-entry program memory
   localparam int DEF_RET_W   = 8;   // retired-instruction counter
   localparam int INSTR_W     = 12;  // instruction word width
   localparam int REG_AW      = 2;   // register-file address width
   localparam int OP_W        = 2;   // opcode / fpu_op width

   // Instruction-word field positions: [11:10] op, [9:8] rd, [7:6] rs1, [5:4] rs2
   localparam int OP_MSB  = 11;
   localparam int OP_LSB  = 10;
   localparam int RD_MSB  = 9;
   localparam int RD_LSB  = 8;
   localparam int RS1_MSB = 7;
   localparam int RS1_LSB = 6;
   localparam int RS2_MSB = 5;
   localparam int RS2_LSB = 4;
   localparam int IGN_MSB = 3;       // [3:0] carries no information

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_MUL  = 2'b10,
      OP_HALT = 2'b11
   } opcode_t;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_ISSUE  = 3'd3,
      S_WAIT   = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   // Extract the opcode field of an instruction word.
   function automatic opcode_t get_opcode(input logic [INSTR_W-1:0] instr);
      return opcode_t'(instr[OP_MSB:OP_LSB]);
   endfunction

endpackage

// File: rtl/seq_pc.sv
// -----------------------------------------------------------------------------
// seq_pc
// Program counter for the FPU sequencer. Wraps modulo 2^IMEM_AW.
//   clk      : clock
//   reset    : synchronous active-high reset (PC <= 0)
//   i_clear  : load PC with 0 (takes priority over i_inc)
//   i_inc    : advance PC by one
//   o_pc     : current PC (registered)
// -----------------------------------------------------------------------------
module seq_pc
   import fpu_seq_pkg::*;
#(
   parameter int IMEM_AW = DEF_IMEM_AW
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_clear,
   input  logic               i_inc,
   output logic [IMEM_AW-1:0] o_pc
);

   logic [IMEM_AW-1:0] r_pc;

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_pc <= '0;
      end else if (i_inc) begin
         // natural overflow gives the 15 -> 0 wrap
         r_pc <= r_pc + IMEM_AW'(1);
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/fpu_sequencer.sv
// -----------------------------------------------------------------------------
// fpu_sequencer
// Fetches 12-bit instructions from a synchronous ROM, issues them to a BF16
// FPU over a valid/ready handshake, waits for the done pulse and writes the
// result back to the register file. Every output is a register.
//   clk, reset           : clock, synchronous active-high reset
//   start                : pulse, starts at address 0 from IDLE or HALT
//   abort                : level, returns to IDLE (beats every other event)
//   imem_addr/imem_data  : instruction fetch (data valid one cycle later)
//   rf_raddr_a/b         : register-file read addresses (rs1, rs2)
//   rf_waddr/rf_we       : register-file write address / one-cycle strobe
//   fpu_op/fpu_valid     : FPU issue request; fpu_ready accepts it
//   fpu_done             : one-cycle pulse, FPU result available
//   busy/halted/retired  : status
// -----------------------------------------------------------------------------
module fpu_sequencer
   import fpu_seq_pkg::*;
#(
   parameter int IMEM_AW = DEF_IMEM_AW,
   parameter int RET_W   = DEF_RET_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [REG_AW-1:0]  rf_raddr_a,
   output logic [REG_AW-1:0]  rf_raddr_b,
   output logic [REG_AW-1:0]  rf_waddr,
   output logic               rf_we,
   output logic [OP_W-1:0]    fpu_op,
   output logic               fpu_valid,
   input  logic               fpu_ready,
   input  logic               fpu_done,
   output logic               busy,
   output logic               halted,
   output logic [RET_W-1:0]   retired
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_fpu_valid;
   logic                r_rf_we;
   logic                r_busy;
   logic                r_halted;
   logic [RET_W-1:0]    r_retired;
   logic [REG_AW-1:0]   r_raddr_a;
   logic [REG_AW-1:0]   r_raddr_b;
   logic [REG_AW-1:0]   r_waddr;
   logic [OP_W-1:0]     r_fpu_op;
   logic                w_pc_clear;
   logic                w_pc_inc;
   logic                w_wb_commit;
   logic                w_unused;

   // Counter that sticks at all-ones instead of wrapping.
   function automatic logic [RET_W-1:0] sat_inc(input logic [RET_W-1:0] v);
      return (&v) ? v : v + RET_W'(1);
   endfunction

   // Low nibble of the instruction word is don't-care.
   assign w_unused = ^imem_data[IGN_MSB:0];

   // A start that is honoured (only from IDLE/HALT, never together with abort)
   // restarts the program at address 0 on the same edge.
   assign w_pc_clear  = start && !abort &&
                        ((r_state == S_IDLE) || (r_state == S_HALT));
   // Write-back commits PC/retired only if not aborted in that same cycle.
   assign w_wb_commit = (r_state == S_WB) && !abort;
   assign w_pc_inc    = w_wb_commit;

   seq_pc #(
      .IMEM_AW (IMEM_AW)
   ) u_pc (
      .clk     (clk),
      .reset   (reset),
      .i_clear (w_pc_clear),
      .i_inc   (w_pc_inc),
      .o_pc    (imem_addr)
   );

   // Next-state decode. fpu_valid is registered high for the whole of ISSUE,
   // so acceptance in ISSUE reduces to fpu_ready. fpu_done is only looked at
   // in WAIT, which drops any stray pulse in other states.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:   if (start) w_state_nxt = S_FETCH;
         S_FETCH:  w_state_nxt = S_DECODE;
         S_DECODE: w_state_nxt = (get_opcode(imem_data) == OP_HALT) ? S_HALT : S_ISSUE;
         S_ISSUE:  if (r_fpu_valid && fpu_ready) w_state_nxt = S_WAIT;
         S_WAIT:   if (fpu_done) w_state_nxt = S_WB;
         S_WB:     w_state_nxt = S_FETCH;
         S_HALT:   if (start) w_state_nxt = S_FETCH;
         default:  w_state_nxt = S_IDLE;
      endcase
      if (abort) begin
         w_state_nxt = S_IDLE;
      end
   end

   // State register plus registered outputs, which are decoded from the
   // next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_fpu_valid <= 1'b0;
         r_rf_we     <= 1'b0;
         r_busy      <= 1'b0;
         r_halted    <= 1'b0;
         r_retired   <= '0;
         r_raddr_a   <= '0;
         r_raddr_b   <= '0;
         r_waddr     <= '0;
         r_fpu_op    <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_fpu_valid <= (w_state_nxt == S_ISSUE);
         r_rf_we     <= (w_state_nxt == S_WB);
         r_halted    <= (w_state_nxt == S_HALT);
         r_busy      <= (w_state_nxt == S_FETCH)  || (w_state_nxt == S_DECODE) ||
                        (w_state_nxt == S_ISSUE)  || (w_state_nxt == S_WAIT)   ||
                        (w_state_nxt == S_WB);

         // Instruction fields are latched once in DECODE and held stable
         // through ISSUE/WAIT/WB.
         if ((r_state == S_DECODE) && !abort &&
             (get_opcode(imem_data) != OP_HALT)) begin
            r_fpu_op  <= imem_data[OP_MSB:OP_LSB];
            r_waddr   <= imem_data[RD_MSB:RD_LSB];
            r_raddr_a <= imem_data[RS1_MSB:RS1_LSB];
            r_raddr_b <= imem_data[RS2_MSB:RS2_LSB];
         end

         if (w_wb_commit) begin
            r_retired <= sat_inc(r_retired);
         end
      end
   end

   assign fpu_valid  = r_fpu_valid;
   assign rf_we      = r_rf_we;
   assign busy       = r_busy;
   assign halted     = r_halted;
   assign retired    = r_retired;
   assign rf_raddr_a = r_raddr_a;
   assign rf_raddr_b = r_raddr_b;
   assign rf_waddr   = r_waddr;
   assign fpu_op     = r_fpu_op;

endmodule

// File: tb/tb_fpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fpu_sequencer
// Directed bench for fpu_sequencer: synchronous ROM model, FPU handshake
// driven step by step, register-file write and FPU-acceptance monitors.
// -----------------------------------------------------------------------------
module tb_fpu_sequencer;
   import fpu_seq_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [3:0]  imem_addr;
   logic [11:0] imem_data;
   logic [1:0]  rf_raddr_a;
   logic [1:0]  rf_raddr_b;
   logic [1:0]  rf_waddr;
   logic        rf_we;
   logic [1:0]  fpu_op;
   logic        fpu_valid;
   logic        fpu_ready;
   logic        fpu_done;
   logic        busy;
   logic        halted;
   logic [7:0]  retired;

   logic [11:0] rom [16];
   int          checks   = 0;
   int          failures = 0;
   int          we_cnt   = 0;
   int          acc_cnt  = 0;
   int          we0;
   int          acc0;

   always #5 clk = ~clk;

   fpu_sequencer #(
      .IMEM_AW (4),
      .RET_W   (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .rf_raddr_a (rf_raddr_a),
      .rf_raddr_b (rf_raddr_b),
      .rf_waddr   (rf_waddr),
      .rf_we      (rf_we),
      .fpu_op     (fpu_op),
      .fpu_valid  (fpu_valid),
      .fpu_ready  (fpu_ready),
      .fpu_done   (fpu_done),
      .busy       (busy),
      .halted     (halted),
      .retired    (retired)
   );

   // Synchronous ROM: data for imem_addr appears one cycle later.
   always @(posedge clk) imem_data <= rom[imem_addr];

   always @(posedge clk) begin
      if (rf_we) we_cnt <= we_cnt + 1;
      if (fpu_valid && fpu_ready) acc_cnt <= acc_cnt + 1;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout obs=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Wait for ISSUE, let the handshake accept (fpu_ready assumed high), then
   // return done one cycle after acceptance. Returns sampled in WB.
   task automatic serve(input string tag);
      int n;
      n = 0;
      while (!fpu_valid && n < 20) begin
         cyc();
         n++;
      end
      chk(tag, 32'(fpu_valid), 1);
      cyc();
      fpu_done = 1'b1;
      cyc();
      fpu_done = 1'b0;
   endtask

   task automatic wait_halt(input string tag);
      int n;
      n = 0;
      while (!halted && n < 30) begin
         cyc();
         n++;
      end
      chk(tag, 32'(halted), 1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      fpu_ready = 1'b1; fpu_done = 1'b0;
      for (int i = 0; i < 16; i++) rom[i] = 12'hC00;
      cyc(); cyc();
      // Reset state (sampled while reset still applied and after release)
      reset = 1'b0;
      chk("rst_busy",    32'(busy), 0);
      chk("rst_halted",  32'(halted), 0);
      chk("rst_valid",   32'(fpu_valid), 0);
      chk("rst_we",      32'(rf_we), 0);
      chk("rst_retired", 32'(retired), 0);
      chk("rst_pc",      32'(imem_addr), 0);
      chk("rst_op",      32'(fpu_op), 0);
      chk("rst_raddr",   32'({rf_raddr_a, rf_raddr_b, rf_waddr}), 0);

      // ---- ADD r1,r2,r3 ; HALT with 5-cycle minimum latency
      rom[0] = 12'h1B0;
      rom[1] = 12'hC00;
      we0 = we_cnt;
      start = 1'b1; cyc(); start = 1'b0;
      chk("t1_fetch_busy", 32'(busy), 1);
      chk("t1_fetch_pc",   32'(imem_addr), 0);
      cyc(); cyc();
      chk("t1_issue_valid", 32'(fpu_valid), 1);
      chk("t1_issue_op",    32'(fpu_op), 0);
      chk("t1_issue_ra",    32'(rf_raddr_a), 2);
      chk("t1_issue_rb",    32'(rf_raddr_b), 3);
      cyc();
      chk("t1_wait_valid", 32'(fpu_valid), 0);
      fpu_done = 1'b1; cyc(); fpu_done = 1'b0;
      chk("t1_wb_we",    32'(rf_we), 1);
      chk("t1_wb_waddr", 32'(rf_waddr), 1);
      cyc();
      chk("t1_refetch_we",   32'(rf_we), 0);
      chk("t1_refetch_pc",   32'(imem_addr), 1);
      chk("t1_refetch_busy", 32'(busy), 1);
      cyc(); cyc();
      chk("t1_halted",  32'(halted), 1);
      chk("t1_hbusy",   32'(busy), 0);
      chk("t1_hpc",     32'(imem_addr), 1);
      chk("t1_retired", 32'(retired), 1);
      chk("t1_wecount", 32'(we_cnt - we0), 1);

      // ---- MUL r3,r1,r2 with fpu_ready low for 4 ISSUE cycles (restart from HALT)
      rom[0] = 12'hB60;
      fpu_ready = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      chk("t2_restart_pc",  32'(imem_addr), 0);
      chk("t2_restart_hlt", 32'(halted), 0);
      chk("t2_restart_ret", 32'(retired), 1);
      cyc(); cyc();
      acc0 = acc_cnt;
      for (int i = 0; i < 4; i++) begin
         chk("t2_stall_valid", 32'(fpu_valid), 1);
         chk("t2_stall_op",    32'(fpu_op), 2);
         chk("t2_stall_ra",    32'(rf_raddr_a), 1);
         chk("t2_stall_rb",    32'(rf_raddr_b), 2);
         chk("t2_stall_pc",    32'(imem_addr), 0);
         start = (i == 1);    // start mid-instruction must be ignored
         if (i < 3) cyc();
      end
      start = 1'b0;
      fpu_ready = 1'b1;
      cyc();
      chk("t2_accept_valid", 32'(fpu_valid), 0);
      chk("t2_accept_count", 32'(acc_cnt - acc0), 1);
      fpu_done = 1'b1; cyc(); fpu_done = 1'b0;
      chk("t2_wb_waddr", 32'(rf_waddr), 3);
      wait_halt("t2_halt");
      chk("t2_retired", 32'(retired), 2);

      // ---- SUB r2,r0,r1 with spurious done in ISSUE
      rom[0] = 12'h610;
      fpu_ready = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      cyc(); cyc();
      we0 = we_cnt;
      fpu_done = 1'b1; cyc(); fpu_done = 1'b0;
      chk("t3_spur_valid", 32'(fpu_valid), 1);
      chk("t3_spur_we",    32'(rf_we), 0);
      fpu_ready = 1'b1; cyc();
      chk("t3_wait_valid", 32'(fpu_valid), 0);
      cyc();
      chk("t3_wait_we", 32'(rf_we), 0);
      fpu_done = 1'b1; cyc(); fpu_done = 1'b0;
      chk("t3_wb_we",    32'(rf_we), 1);
      chk("t3_wb_waddr", 32'(rf_waddr), 2);
      wait_halt("t3_halt");
      chk("t3_wecount", 32'(we_cnt - we0), 1);
      chk("t3_retired", 32'(retired), 3);

      // ---- 16 non-HALT instructions, PC wraps 15 -> 0
      reset = 1'b1; cyc(); reset = 1'b0;
      for (int i = 0; i < 16; i++) rom[i] = {2'(i % 3), 2'(i % 4), 2'b01, 2'b10, 4'h0};
      start = 1'b1; cyc(); start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         serve("t4_serve");
         chk("t4_waddr", 32'(rf_waddr), 32'(i % 4));
      end
      cyc();
      chk("t4_wrap_pc",  32'(imem_addr), 0);
      chk("t4_retired",  32'(retired), 16);
      chk("t4_nohalt",   32'(halted), 0);
      chk("t4_busy",     32'(busy), 1);

      // ---- abort in WAIT, then start+abort together
      cyc(); cyc(); cyc();
      we0 = we_cnt;
      abort = 1'b1; fpu_done = 1'b1; cyc(); abort = 1'b0; fpu_done = 1'b0;
      chk("t5_abort_busy",  32'(busy), 0);
      chk("t5_abort_valid", 32'(fpu_valid), 0);
      chk("t5_abort_we",    32'(rf_we), 0);
      chk("t5_abort_pc",    32'(imem_addr), 0);
      chk("t5_abort_ret",   32'(retired), 16);
      cyc();
      chk("t5_abort_nowb", 32'(we_cnt - we0), 0);
      start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
      chk("t5_sa_busy", 32'(busy), 0);
      cyc();
      chk("t5_sa_idle",   32'(busy), 0);
      chk("t5_sa_halted", 32'(halted), 0);

      // ---- reset during ISSUE
      rom[0] = 12'hB60;
      fpu_ready = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      cyc(); cyc();
      chk("t6_issue_valid", 32'(fpu_valid), 1);
      chk("t6_issue_op",    32'(fpu_op), 2);
      we0 = we_cnt;
      reset = 1'b1; cyc();
      chk("t6_rst_valid", 32'(fpu_valid), 0);
      chk("t6_rst_busy",  32'(busy), 0);
      chk("t6_rst_we",    32'(rf_we), 0);
      chk("t6_rst_ret",   32'(retired), 0);
      chk("t6_rst_pc",    32'(imem_addr), 0);
      chk("t6_rst_op",    32'(fpu_op), 0);
      chk("t6_rst_addr",  32'({rf_raddr_a, rf_raddr_b, rf_waddr}), 0);
      reset = 1'b0; fpu_ready = 1'b1; cyc();
      chk("t6_no_we", 32'(we_cnt - we0), 0);

      // ---- retired saturates at 255
      for (int i = 0; i < 16; i++) rom[i] = 12'h1B0;
      start = 1'b1; cyc(); start = 1'b0;
      for (int k = 0; k < 255; k++) serve("t7_serve");
      cyc();
      chk("t7_ret_255", 32'(retired), 255);
      serve("t7_serve_last");
      cyc();
      chk("t7_ret_sat", 32'(retired), 255);
      abort = 1'b1; cyc(); abort = 1'b0;
      chk("t7_idle", 32'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
